// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock; define SEQ_DIV_DZ_EN for dz port and early divide-by-zero exit
module seq_divider #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] q,
  output logic [width-1:0] r
`ifdef SEQ_DIV_DZ_EN
  ,
  output logic             dz
`endif
);
  localparam int cw = $clog2(width + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [width-1:0] dvd, dvs;
  logic [width:0] rem, rem_n;
  logic [width+1:0] sh, tr;
  logic [cw-1:0] cnt;
  logic ge, skip, last;
`ifdef SEQ_DIV_DZ_EN
  assign skip = b == '0;
`else
  assign skip = 1'b0;
`endif
  assign last = cnt == cw'(1);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state: accept from IDLE, count down in RUN, DONE lasts one cycle
  always_comb begin
    nxt = state == IDLE ? (start ? (skip ? DONE : RUN) : IDLE)
        : state == RUN  ? (last ? DONE : RUN)
        : IDLE;
  end
  // one restoring step: shift in the next dividend bit and trial-subtract the divisor
  always_comb begin
    sh = {rem, dvd[width-1]};
    tr = sh - {2'b00, dvs};
    ge = sh >= {2'b00, dvs};
    rem_n = (width+1)'(ge ? tr : sh);
  end
  // datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      q <= '0;
      r <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
`ifdef SEQ_DIV_DZ_EN
      dz <= 1'b0;
`endif
    end else begin
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      if (state == IDLE && start) begin
        dvd <= a;
        dvs <= b;
        rem <= '0;
        cnt <= cw'(width);
`ifdef SEQ_DIV_DZ_EN
        dz <= skip;
        if (skip) begin
          q <= '1;
          r <= a;
        end
`endif
      end else if (state == RUN) begin
        dvd <= {dvd[width-2:0], ge};
        rem <= rem_n;
        cnt <= cnt - cw'(1);
        if (last) begin
          q <= {dvd[width-2:0], ge};
          r <= rem_n[width-1:0];
        end
      end
    end
endmodule
